// File: rtl/intr_ack_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer: FSM state
// encoding and the default INTA# pulse/gap lengths.
package intr_ack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INTA1   = 3'd1,
    ST_GAP     = 3'd2,
    ST_INTA2   = 3'd3,
    ST_PRESENT = 3'd4
  } state_e;

  localparam int unsigned DEFAULT_INTA_LOW_CYCLES = 32'd4;
  localparam int unsigned DEFAULT_INTA_GAP_CYCLES = 32'd2;

endpackage

// File: rtl/intr_ack_phase_timer.sv
// 8-bit down-counter timing each INTA# phase. A load presets the phase
// length minus one; terminal_count flags the last clock of the phase.
module intr_ack_phase_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       terminal_count
);

  logic [7:0] count_r;

  // Phase counter: reload on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= 8'h00;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != 8'h00) begin
      count_r <= count_r - 8'h01;
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal_count = (count_r == 8'h00);

endmodule

// File: rtl/intr_ack_sequencer.sv
// Two-pulse interrupt acknowledge sequencer: accepts INTR when enabled,
// issues two INTA# pulses with bus lock, captures the type byte during the
// second pulse and holds it for the CPU core until accepted.
module intr_ack_sequencer
  import intr_ack_pkg::*;
#(
  parameter int unsigned INTA_LOW_CYCLES = DEFAULT_INTA_LOW_CYCLES,
  parameter int unsigned INTA_GAP_CYCLES = DEFAULT_INTA_GAP_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt,
  input  logic       interrupt_enable,
  output logic       interrupt_acknowledge_n,
  output logic       bus_lock,
  input  logic [7:0] data_bus_in,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ready,
  output logic       busy
);

  localparam logic [7:0] LOW_LOAD = 8'(INTA_LOW_CYCLES - 32'd1);
  localparam logic [7:0] GAP_LOAD = 8'(INTA_GAP_CYCLES - 32'd1);

  state_e     state_r;
  state_e     next_state_s;
  logic       load_s;
  logic [7:0] load_value_s;
  logic       capture_s;
  logic       terminal_count_s;
  logic       inta_n_r;
  logic       bus_lock_r;
  logic [7:0] vector_r;
  logic       vector_valid_r;
  logic       busy_r;

  intr_ack_phase_timer u_phase_timer (
    .clock          (clock),
    .reset          (reset),
    .load           (load_s),
    .load_value     (load_value_s),
    .terminal_count (terminal_count_s)
  );

  // Next-state logic, phase counter load requests and vector capture strobe.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    load_value_s = 8'h00;
    capture_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (interrupt && interrupt_enable) begin
          next_state_s = ST_INTA1;
          load_s       = 1'b1;
          load_value_s = LOW_LOAD;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_INTA1: begin
        if (terminal_count_s) begin
          next_state_s = ST_GAP;
          load_s       = 1'b1;
          load_value_s = GAP_LOAD;
        end else begin
          next_state_s = ST_INTA1;
        end
      end
      ST_GAP: begin
        if (terminal_count_s) begin
          next_state_s = ST_INTA2;
          load_s       = 1'b1;
          load_value_s = LOW_LOAD;
        end else begin
          next_state_s = ST_GAP;
        end
      end
      ST_INTA2: begin
        if (terminal_count_s) begin
          next_state_s = ST_PRESENT;
          capture_s    = 1'b1;
        end else begin
          next_state_s = ST_INTA2;
        end
      end
      ST_PRESENT: begin
        if (vector_valid_r && vector_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_PRESENT;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register and outputs, all derived from the next state so every
  // output comes straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      inta_n_r       <= 1'b1;
      bus_lock_r     <= 1'b0;
      vector_r       <= 8'h00;
      vector_valid_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      inta_n_r       <= !((next_state_s == ST_INTA1) || (next_state_s == ST_INTA2));
      bus_lock_r     <= (next_state_s == ST_INTA1) || (next_state_s == ST_GAP) ||
                        (next_state_s == ST_INTA2);
      vector_valid_r <= (next_state_s == ST_PRESENT);
      busy_r         <= (next_state_s != ST_IDLE);
      if (capture_s) begin
        vector_r <= data_bus_in;
      end else begin
        vector_r <= vector_r;
      end
    end
  end

  assign interrupt_acknowledge_n = inta_n_r;
  assign bus_lock                = bus_lock_r;
  assign vector                  = vector_r;
  assign vector_valid            = vector_valid_r;
  assign busy                    = busy_r;

endmodule
